// File: rtl/btn_led_ctrl.sv
// Button-to-LED controller: synchronises and debounces buttons, then drives
// LEDs in reversed, direct, toggle-latch or rotating-chaser mode chosen by sw.
module btn_led_ctrl #(
  parameter int N_CH            = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1250000,
  parameter int CHASE_CYCLES    = 12500000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn,
  input  logic [1:0]      sw,
  output logic [N_CH-1:0] led,
  output logic [N_CH-1:0] btn_db,
  output logic [N_CH-1:0] btn_rise
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int CH_W = $clog2(CHASE_CYCLES) + 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(CHASE_CYCLES - 1);

  localparam logic [1:0] MODE_REV   = 2'b00;
  localparam logic [1:0] MODE_DIR   = 2'b01;
  localparam logic [1:0] MODE_TOG   = 2'b10;
  localparam logic [1:0] MODE_CHASE = 2'b11;

  logic [N_CH-1:0] btn_sync_q [SYNC_STAGES];
  logic [N_CH-1:0] btn_sync_d [SYNC_STAGES];
  logic [1:0]      sw_sync_q  [SYNC_STAGES];
  logic [1:0]      sw_sync_d  [SYNC_STAGES];
  logic [DB_W-1:0] db_cnt_q   [N_CH];
  logic [DB_W-1:0] db_cnt_d   [N_CH];

  logic [N_CH-1:0] btn_db_q, btn_db_d;
  logic [N_CH-1:0] btn_rise_q, btn_rise_d;
  logic [N_CH-1:0] tog_q, tog_d;
  logic [N_CH-1:0] pos_q, pos_d;
  logic [N_CH-1:0] led_q, led_d;
  logic [CH_W-1:0] presc_q, presc_d;
  logic            dir_up_q, dir_up_d;

  logic [N_CH-1:0] btn_s;
  logic [1:0]      mode;
  logic [1:0]      mode_next;
  logic            enter_chase;

  always_comb begin
    btn_sync_d[0] = btn;
    sw_sync_d[0]  = sw;
    for (int s = 1; s < SYNC_STAGES; s++) begin
      btn_sync_d[s] = btn_sync_q[s-1];
      sw_sync_d[s]  = sw_sync_q[s-1];
    end
    btn_s     = btn_sync_q[SYNC_STAGES-1];
    mode      = sw_sync_q[SYNC_STAGES-1];
    mode_next = sw_sync_q[SYNC_STAGES-2];
  end

  always_comb begin
    btn_db_d   = btn_db_q;
    btn_rise_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      db_cnt_d[i] = '0;
      if (btn_s[i] != btn_db_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          btn_db_d[i]   = ~btn_db_q[i];
          btn_rise_d[i] = ~btn_db_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // Entry is detected one stage early so the reset position is already
  // in pos_q when the new mode first reaches the LED register.
  always_comb begin
    tog_d       = tog_q;
    dir_up_d    = dir_up_q;
    presc_d     = presc_q;
    pos_d       = pos_q;
    enter_chase = (mode_next == MODE_CHASE) && (mode != MODE_CHASE);

    if (mode == MODE_TOG) begin
      tog_d = tog_q ^ btn_rise_q;
    end

    if (mode == MODE_CHASE) begin
      if (btn_rise_q[0] && !btn_rise_q[N_CH-1]) begin
        dir_up_d = 1'b1;
      end else if (!btn_rise_q[0] && btn_rise_q[N_CH-1]) begin
        dir_up_d = 1'b0;
      end
    end

    if (enter_chase) begin
      presc_d = '0;
      pos_d   = N_CH'(1);
    end else if (mode == MODE_CHASE) begin
      if (presc_q == CH_LAST) begin
        presc_d = '0;
        pos_d   = dir_up_q ? {pos_q[N_CH-2:0], pos_q[N_CH-1]}
                           : {pos_q[0], pos_q[N_CH-1:1]};
      end else begin
        presc_d = presc_q + CH_W'(1);
      end
    end
  end

  always_comb begin
    led_d = '0;
    case (mode)
      MODE_REV: begin
        for (int i = 0; i < N_CH; i++) begin
          led_d[i] = btn_db_q[N_CH-1-i];
        end
      end
      MODE_DIR:   led_d = btn_db_q;
      MODE_TOG:   led_d = tog_q;
      MODE_CHASE: led_d = pos_q;
      default:    led_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        btn_sync_q[s] <= '0;
        sw_sync_q[s]  <= '0;
      end
      for (int i = 0; i < N_CH; i++) begin
        db_cnt_q[i] <= '0;
      end
      btn_db_q   <= '0;
      btn_rise_q <= '0;
      tog_q      <= '0;
      pos_q      <= N_CH'(1);
      dir_up_q   <= 1'b1;
      presc_q    <= '0;
      led_q      <= '0;
    end else begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        btn_sync_q[s] <= btn_sync_d[s];
        sw_sync_q[s]  <= sw_sync_d[s];
      end
      for (int i = 0; i < N_CH; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
      btn_db_q   <= btn_db_d;
      btn_rise_q <= btn_rise_d;
      tog_q      <= tog_d;
      pos_q      <= pos_d;
      dir_up_q   <= dir_up_d;
      presc_q    <= presc_d;
      led_q      <= led_d;
    end
  end

  assign led      = led_q;
  assign btn_db   = btn_db_q;
  assign btn_rise = btn_rise_q;

endmodule

// File: tb/tb_btn_led_ctrl.sv
// Directed bench for btn_led_ctrl with small debounce/chase constants; all
// expected values are hand-derived cycle counts from the input edge.
module tb_btn_led_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] btn;
  logic [1:0] sw;
  logic [3:0] led;
  logic [3:0] btn_db;
  logic [3:0] btn_rise;

  int passCount  = 0;
  int checkCount = 0;

  btn_led_ctrl #(
    .N_CH(4),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4),
    .CHASE_CYCLES(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn(btn),
    .sw(sw),
    .led(led),
    .btn_db(btn_db),
    .btn_rise(btn_rise)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] b, input logic [1:0] s);
    btn = b;
    sw  = s;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] expLed,
                             input logic [3:0] expDb, input logic [3:0] expRise);
    checkCount++;
    assert (led === expLed) begin
      passCount++;
    end else begin
      $error("[TB] FAIL %s led: observed %b expected %b", tag, led, expLed);
    end
    checkCount++;
    assert (btn_db === expDb) begin
      passCount++;
    end else begin
      $error("[TB] FAIL %s btn_db: observed %b expected %b", tag, btn_db, expDb);
    end
    checkCount++;
    assert (btn_rise === expRise) begin
      passCount++;
    end else begin
      $error("[TB] FAIL %s btn_rise: observed %b expected %b", tag, btn_rise, expRise);
    end
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(4'b0000, 2'b00);
    tick(2);
    checkOutput("reset", 4'b0000, 4'b0000, 4'b0000);
    rst = 1'b0;

    $display("[TB] debounce latency");
    applyStimulus(4'b0000, 2'b01);
    tick(4);
    checkOutput("idle_direct", 4'b0000, 4'b0000, 4'b0000);
    applyStimulus(4'b0001, 2'b01);
    tick(5);
    checkOutput("db_clk5", 4'b0000, 4'b0000, 4'b0000);
    tick(1);
    checkOutput("db_clk6", 4'b0000, 4'b0001, 4'b0001);
    tick(1);
    checkOutput("db_clk7", 4'b0001, 4'b0001, 4'b0000);

    $display("[TB] glitch reject");
    applyStimulus(4'b0000, 2'b01);
    tick(8);
    checkOutput("release0", 4'b0000, 4'b0000, 4'b0000);
    applyStimulus(4'b0100, 2'b01);
    repeat (3) begin
      tick(1);
      checkOutput("glitch_hi", 4'b0000, 4'b0000, 4'b0000);
    end
    applyStimulus(4'b0000, 2'b01);
    repeat (8) begin
      tick(1);
      checkOutput("glitch_lo", 4'b0000, 4'b0000, 4'b0000);
    end
    applyStimulus(4'b0100, 2'b01);
    tick(4);
    applyStimulus(4'b0000, 2'b01);
    tick(2);
    checkOutput("pulse4_db", 4'b0000, 4'b0100, 4'b0100);
    tick(1);
    checkOutput("pulse4_led", 4'b0100, 4'b0100, 4'b0000);
    tick(8);
    checkOutput("pulse4_rel", 4'b0000, 4'b0000, 4'b0000);

    $display("[TB] reversed and direct");
    applyStimulus(4'b0011, 2'b00);
    tick(8);
    checkOutput("reversed", 4'b1100, 4'b0011, 4'b0000);
    applyStimulus(4'b0011, 2'b01);
    tick(2);
    checkOutput("sw_lat2", 4'b1100, 4'b0011, 4'b0000);
    tick(1);
    checkOutput("sw_lat3", 4'b0011, 4'b0011, 4'b0000);

    $display("[TB] toggle");
    applyStimulus(4'b0000, 2'b01);
    tick(8);
    checkOutput("tog_prep", 4'b0000, 4'b0000, 4'b0000);
    applyStimulus(4'b0000, 2'b10);
    tick(4);
    checkOutput("tog_init", 4'b0000, 4'b0000, 4'b0000);
    applyStimulus(4'b0010, 2'b10);
    tick(8);
    checkOutput("tog_p1", 4'b0010, 4'b0010, 4'b0000);
    applyStimulus(4'b0000, 2'b10);
    tick(8);
    checkOutput("tog_r1", 4'b0010, 4'b0000, 4'b0000);
    applyStimulus(4'b0010, 2'b10);
    tick(8);
    checkOutput("tog_p2", 4'b0000, 4'b0010, 4'b0000);
    applyStimulus(4'b0000, 2'b10);
    tick(8);
    checkOutput("tog_r2", 4'b0000, 4'b0000, 4'b0000);
    applyStimulus(4'b0010, 2'b10);
    tick(8);
    checkOutput("tog_p3", 4'b0010, 4'b0010, 4'b0000);
    applyStimulus(4'b0000, 2'b10);
    tick(8);
    checkOutput("tog_r3", 4'b0010, 4'b0000, 4'b0000);
    applyStimulus(4'b0000, 2'b01);
    tick(3);
    checkOutput("tog_away", 4'b0000, 4'b0000, 4'b0000);
    applyStimulus(4'b0000, 2'b10);
    tick(3);
    checkOutput("tog_back", 4'b0010, 4'b0000, 4'b0000);

    $display("[TB] chaser");
    applyStimulus(4'b0000, 2'b11);
    tick(3);
    checkOutput("chase_e3", 4'b0001, 4'b0000, 4'b0000);
    tick(2);
    checkOutput("chase_e5", 4'b0001, 4'b0000, 4'b0000);
    tick(1);
    checkOutput("chase_e6", 4'b0010, 4'b0000, 4'b0000);
    tick(3);
    checkOutput("chase_e9", 4'b0100, 4'b0000, 4'b0000);
    tick(3);
    checkOutput("chase_e12", 4'b1000, 4'b0000, 4'b0000);
    tick(3);
    checkOutput("chase_wrap", 4'b0001, 4'b0000, 4'b0000);
    tick(2);
    applyStimulus(4'b1000, 2'b11);
    tick(7);
    checkOutput("chase_e24", 4'b1000, 4'b1000, 4'b0000);
    tick(3);
    checkOutput("chase_down", 4'b0100, 4'b1000, 4'b0000);
    applyStimulus(4'b0000, 2'b11);
    tick(6);
    checkOutput("chase_e33", 4'b0001, 4'b0000, 4'b0000);
    applyStimulus(4'b1001, 2'b11);
    tick(9);
    checkOutput("chase_both", 4'b0010, 4'b1001, 4'b0000);
    tick(3);
    checkOutput("chase_e45", 4'b0001, 4'b1001, 4'b0000);

    $display("[TB] reset mid-chase");
    applyStimulus(4'b0000, 2'b11);
    tick(6);
    checkOutput("pre_rst", 4'b0100, 4'b0000, 4'b0000);
    rst = 1'b1;
    tick(1);
    checkOutput("mid_rst", 4'b0000, 4'b0000, 4'b0000);
    rst = 1'b0;
    tick(2);
    checkOutput("rst_r2", 4'b0000, 4'b0000, 4'b0000);
    tick(1);
    checkOutput("rst_r3", 4'b0001, 4'b0000, 4'b0000);
    tick(3);
    checkOutput("rst_up", 4'b0010, 4'b0000, 4'b0000);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
